// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// rv32_pkg : RV32I opcodes, instruction field layout and immediate generation
// Rev 1.0
// ============================================================================
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam int REG_AW = 5;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rv_instr_t;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   function automatic imm_type_e imm_type(input logic [6:0] opc);
      imm_type_e t;
      case (opc)
         OPC_OPIMM, OPC_LOAD, OPC_JALR: t = IMM_I;
         OPC_STORE:                     t = IMM_S;
         OPC_BRANCH:                    t = IMM_B;
         OPC_LUI, OPC_AUIPC:            t = IMM_U;
         OPC_JAL:                       t = IMM_J;
         default:                       t = IMM_NONE;
      endcase
      return t;
   endfunction

   function automatic logic [31:0] gen_imm(input logic [31:0] ir);
      logic [31:0] imm;
      case (imm_type(ir[6:0]))
         IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
         IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_U:   imm = {ir[31:12], 12'h000};
         IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm = 32'h0;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// regfile_2r1w : 2 async read / 1 sync write register file, x0 reads zero,
//                same-cycle write is bypassed to the read ports
// Rev 1.0
// ============================================================================
module regfile_2r1w #(
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wen,
   input  logic [AW-1:0] i_wa,
   input  logic [31:0]   i_wd,
   input  logic [AW-1:0] i_ra1,
   input  logic [AW-1:0] i_ra2,
   output logic [31:0]   o_rd1,
   output logic [31:0]   o_rd2
);

   logic [31:0] mem_q [NREGS];
   logic [31:0] mem_d [NREGS];
   logic        w_wr;

   assign w_wr = i_wen && (i_wa != '0);

   always_comb begin
      mem_d = mem_q;
      if (w_wr) begin
         mem_d[i_wa] = i_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      o_rd1 = mem_q[i_ra1];
      o_rd2 = mem_q[i_ra2];
      if (w_wr && (i_wa == i_ra1)) o_rd1 = i_wd;
      if (w_wr && (i_wa == i_ra2)) o_rd2 = i_wd;
      if (i_ra1 == '0)             o_rd1 = 32'h0;
      if (i_ra2 == '0)             o_rd2 = 32'h0;
   end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : RV32I decode with register file, immediate generation,
//                RAW scoreboard and the DE->EX pipeline register
// Rev 1.0
// ============================================================================
module decode_stage
   import rv32_pkg::*;
#(
   parameter int PC_W  = 16,
   parameter int NREGS = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            DE_V,
   input  logic [31:0]     DE_IR,
   input  logic [PC_W-1:0] DE_PC,
   input  logic            ME_BRT,
   input  logic            WB_WEN,
   input  logic [4:0]      WB_RD,
   input  logic [31:0]     WB_DATA,
   output logic            DE_STALL,
   output logic            EX_V,
   output logic [PC_W-1:0] EX_PC,
   output logic [31:0]     EX_IR,
   output logic [31:0]     EX_RS1_VAL,
   output logic [31:0]     EX_RS2_VAL,
   output logic [31:0]     EX_IMM,
   output logic [4:0]      EX_RD,
   output logic            EX_WEN
);

   rv_instr_t       de_ir;
   logic            rs1_used;
   logic            rs2_used;
   logic            writes_rd;
   logic            rs1_hazard;
   logic            rs2_hazard;
   logic            stall;
   logic            issue;
   logic [31:0]     rs1_val;
   logic [31:0]     rs2_val;

   logic            ex_v_q,   ex_v_d;
   logic [PC_W-1:0] ex_pc_q,  ex_pc_d;
   logic [31:0]     ex_ir_q,  ex_ir_d;
   logic [31:0]     ex_rs1_q, ex_rs1_d;
   logic [31:0]     ex_rs2_q, ex_rs2_d;
   logic [31:0]     ex_imm_q, ex_imm_d;
   logic [4:0]      ex_rd_q,  ex_rd_d;
   logic            ex_wen_q, ex_wen_d;
   logic [NREGS-1:0] busy_q,  busy_d;

   assign de_ir = DE_IR;

   regfile_2r1w #(
      .NREGS (NREGS),
      .AW    (REG_AW)
   ) u_regfile (
      .clk   (CLK),
      .rst   (RST),
      .i_wen (WB_WEN),
      .i_wa  (WB_RD),
      .i_wd  (WB_DATA),
      .i_ra1 (de_ir.rs1),
      .i_ra2 (de_ir.rs2),
      .o_rd1 (rs1_val),
      .o_rd2 (rs2_val)
   );

   always_comb begin
      rs1_used  = !(de_ir.opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
      rs2_used  = de_ir.opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
      writes_rd = (de_ir.opcode inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI,
                                        OPC_AUIPC, OPC_JAL, OPC_JALR})
                  && (de_ir.rd != 5'd0);
      // A producer writing back this cycle is already visible through the bypass
      rs1_hazard = rs1_used && busy_q[de_ir.rs1] && !(WB_WEN && (WB_RD == de_ir.rs1));
      rs2_hazard = rs2_used && busy_q[de_ir.rs2] && !(WB_WEN && (WB_RD == de_ir.rs2));
      stall      = DE_V && !ME_BRT && !RST && (rs1_hazard || rs2_hazard);
      issue      = DE_V && !stall && !ME_BRT;
   end

   assign DE_STALL = stall;

   always_comb begin
      ex_v_d   = issue;
      ex_pc_d  = ex_pc_q;
      ex_ir_d  = ex_ir_q;
      ex_rs1_d = ex_rs1_q;
      ex_rs2_d = ex_rs2_q;
      ex_imm_d = ex_imm_q;
      ex_rd_d  = ex_rd_q;
      ex_wen_d = ex_wen_q;
      if (issue) begin
         ex_pc_d  = DE_PC;
         ex_ir_d  = DE_IR;
         ex_rs1_d = rs1_val;
         ex_rs2_d = rs2_val;
         ex_imm_d = gen_imm(DE_IR);
         ex_rd_d  = de_ir.rd;
         ex_wen_d = writes_rd;
      end
   end

   // Clears are applied before the issue set so a same-cycle set wins
   always_comb begin
      busy_d = busy_q;
      if (WB_WEN) begin
         busy_d[WB_RD] = 1'b0;
      end
      if (ME_BRT && ex_v_q && ex_wen_q) begin
         busy_d[ex_rd_q] = 1'b0;
      end
      if (issue && writes_rd) begin
         busy_d[de_ir.rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_v_q   <= 1'b0;
         ex_pc_q  <= '0;
         ex_ir_q  <= '0;
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
         ex_imm_q <= '0;
         ex_rd_q  <= '0;
         ex_wen_q <= 1'b0;
         busy_q   <= '0;
      end else begin
         ex_v_q   <= ex_v_d;
         ex_pc_q  <= ex_pc_d;
         ex_ir_q  <= ex_ir_d;
         ex_rs1_q <= ex_rs1_d;
         ex_rs2_q <= ex_rs2_d;
         ex_imm_q <= ex_imm_d;
         ex_rd_q  <= ex_rd_d;
         ex_wen_q <= ex_wen_d;
         busy_q   <= busy_d;
      end
   end

   assign EX_V       = ex_v_q;
   assign EX_PC      = ex_pc_q;
   assign EX_IR      = ex_ir_q;
   assign EX_RS1_VAL = ex_rs1_q;
   assign EX_RS2_VAL = ex_rs2_q;
   assign EX_IMM     = ex_imm_q;
   assign EX_RD      = ex_rd_q;
   assign EX_WEN     = ex_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_stage : directed and random stimulus against an instruction-level
//                   reference model of the decode stage
// Rev 1.0
// ============================================================================
module tb_decode_stage;

   localparam logic [6:0] M_OP = 7'h33, M_OPIMM = 7'h13, M_LOAD = 7'h03, M_STORE = 7'h23,
                          M_BRANCH = 7'h63, M_JAL = 7'h6F, M_JALR = 7'h67, M_LUI = 7'h37,
                          M_AUIPC = 7'h17, M_BAD = 7'h7F;

   logic        clk;
   logic        rst;
   logic        de_v;
   logic [31:0] de_ir;
   logic [15:0] de_pc;
   logic        me_brt;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        de_stall;
   logic        ex_v;
   logic [15:0] ex_pc;
   logic [31:0] ex_ir;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_wen;

   decode_stage #(.PC_W(16), .NREGS(32)) dut (
      .CLK        (clk),
      .RST        (rst),
      .DE_V       (de_v),
      .DE_IR      (de_ir),
      .DE_PC      (de_pc),
      .ME_BRT     (me_brt),
      .WB_WEN     (wb_wen),
      .WB_RD      (wb_rd),
      .WB_DATA    (wb_data),
      .DE_STALL   (de_stall),
      .EX_V       (ex_v),
      .EX_PC      (ex_pc),
      .EX_IR      (ex_ir),
      .EX_RS1_VAL (ex_rs1_val),
      .EX_RS2_VAL (ex_rs2_val),
      .EX_IMM     (ex_imm),
      .EX_RD      (ex_rd),
      .EX_WEN     (ex_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: architectural registers, in-flight writers, EX slot
   logic [31:0] regs_m [32];
   logic [31:0] busy_m;
   logic        ex_v_m;
   logic [15:0] ex_pc_m;
   logic [31:0] ex_ir_m, ex_rs1_m, ex_rs2_m, ex_imm_m;
   logic [4:0]  ex_rd_m;
   logic        ex_wen_m;
   logic        stall_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] exp_imm(input logic [31:0] ir);
      int s;
      s = int'(ir);
      case (ir[6:0])
         M_OPIMM, M_LOAD, M_JALR: return s >>> 20;
         M_STORE:  return ((s >>> 25) * 32) + int'(ir[11:7]);
         M_BRANCH: return (s < 0 ? -4096 : 0) + int'(ir[7]) * 2048
                          + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2;
         M_LUI, M_AUIPC: return ir & 32'hFFFFF000;
         M_JAL:    return (s < 0 ? -(1 << 20) : 0) + int'(ir[19:12]) * 4096
                          + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2;
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] read_m(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wb_wen && wb_rd == r) return wb_data;
      return regs_m[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
      busy_m   = 32'h0;
      ex_v_m   = 1'b0;
      ex_pc_m  = 16'h0;
      ex_ir_m  = 32'h0;
      ex_rs1_m = 32'h0;
      ex_rs2_m = 32'h0;
      ex_imm_m = 32'h0;
      ex_rd_m  = 5'h0;
      ex_wen_m = 1'b0;
      stall_prev = 1'b0;
   endtask

   task automatic check_ex();
      check("ex_v", 32'(ex_v), 32'(ex_v_m));
      check("busy", dut.busy_q, busy_m);
      if (ex_v_m) begin
         check("ex_pc",  32'(ex_pc), 32'(ex_pc_m));
         check("ex_ir",  ex_ir, ex_ir_m);
         check("ex_rs1", ex_rs1_val, ex_rs1_m);
         check("ex_rs2", ex_rs2_val, ex_rs2_m);
         check("ex_imm", ex_imm, ex_imm_m);
         check("ex_rd",  32'(ex_rd), 32'(ex_rd_m));
         check("ex_wen", 32'(ex_wen), 32'(ex_wen_m));
      end
   endtask

   // One clock: check the combinational stall, advance DUT and model, check EX
   task automatic cycle();
      logic [6:0]  opc;
      logic [4:0]  rd, rs1, rs2;
      logic        u1, u2, wr, stall_m, iss;
      logic [31:0] nb, v1, v2;
      #2;
      opc = de_ir[6:0];
      rd  = de_ir[11:7];
      rs1 = de_ir[19:15];
      rs2 = de_ir[24:20];
      u1  = !(opc inside {M_LUI, M_AUIPC, M_JAL});
      u2  = opc inside {M_OP, M_STORE, M_BRANCH};
      wr  = (opc inside {M_OP, M_OPIMM, M_LOAD, M_LUI, M_AUIPC, M_JAL, M_JALR}) && rd != 5'd0;
      stall_m = de_v && !me_brt &&
                ((u1 && busy_m[rs1] && !(wb_wen && wb_rd == rs1)) ||
                 (u2 && busy_m[rs2] && !(wb_wen && wb_rd == rs2)));
      iss = de_v && !stall_m && !me_brt;
      v1  = read_m(rs1);
      v2  = read_m(rs2);
      check("de_stall", 32'(de_stall), 32'(stall_m));
      nb = busy_m;
      if (wb_wen) nb[wb_rd] = 1'b0;
      if (me_brt && ex_v_m && ex_wen_m) nb[ex_rd_m] = 1'b0;
      if (iss && wr) nb[rd] = 1'b1;
      nb[0] = 1'b0;
      @(posedge clk);
      if (wb_wen && wb_rd != 5'd0) regs_m[wb_rd] = wb_data;
      busy_m = nb;
      ex_v_m = iss;
      if (iss) begin
         ex_pc_m  = de_pc;
         ex_ir_m  = de_ir;
         ex_rs1_m = v1;
         ex_rs2_m = v2;
         ex_imm_m = exp_imm(de_ir);
         ex_rd_m  = rd;
         ex_wen_m = wr;
      end
      stall_prev = stall_m;
      #1;
      check_ex();
   endtask

   task automatic drive(input logic v, input logic [31:0] ir, input logic [15:0] pc,
                        input logic brt, input logic wen, input logic [4:0] wrd,
                        input logic [31:0] wd);
      de_v = v; de_ir = ir; de_pc = pc; me_brt = brt;
      wb_wen = wen; wb_rd = wrd; wb_data = wd;
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      de_v = 1'b0; me_brt = 1'b0; wb_wen = 1'b0;
      model_reset();
      #1;
      check("rst_ex_v",   32'(ex_v), 32'h0);
      check("rst_ex_pc",  32'(ex_pc), 32'h0);
      check("rst_ex_ir",  ex_ir, 32'h0);
      check("rst_ex_rs1", ex_rs1_val, 32'h0);
      check("rst_ex_rs2", ex_rs2_val, 32'h0);
      check("rst_ex_imm", ex_imm, 32'h0);
      check("rst_ex_rd",  32'(ex_rd), 32'h0);
      check("rst_ex_wen", 32'(ex_wen), 32'h0);
      check("rst_stall",  32'(de_stall), 32'h0);
      check("rst_busy",   dut.busy_q, 32'h0);
      check("rst_x5",     dut.u_regfile.mem_q[5], 32'h0);
   endtask

   task automatic rand_instr(output logic [31:0] ir);
      logic [6:0] opcs [10];
      logic [6:0] opc;
      opcs = '{M_OP, M_OPIMM, M_LOAD, M_STORE, M_BRANCH, M_JAL, M_JALR, M_LUI, M_AUIPC, M_BAD};
      opc = opcs[$urandom_range(0, 9)];
      ir = $urandom;
      ir[6:0] = opc;
      if (!(opc inside {M_STORE, M_BRANCH})) ir[11:7] = 5'($urandom_range(0, 7));
      if (!(opc inside {M_LUI, M_AUIPC, M_JAL})) ir[19:15] = 5'($urandom_range(0, 7));
      if (opc inside {M_OP, M_STORE, M_BRANCH}) ir[24:20] = 5'($urandom_range(0, 7));
   endtask

   initial begin
      logic [31:0] ir;
      rst = 1'b1; de_v = 1'b0; de_ir = 32'h0; de_pc = 16'h0; me_brt = 1'b0;
      wb_wen = 1'b0; wb_rd = 5'h0; wb_data = 32'h0;
      model_reset();

      // Reset state
      do_reset();

      // ADDI x1,x0,5 issues next cycle and marks x1 busy
      drive(1'b1, 32'h00500093, 16'h0000, 1'b0, 1'b0, 5'd0, 32'h0);
      check("addi_imm",  ex_imm, 32'd5);
      check("addi_rd",   32'(ex_rd), 32'd1);
      check("addi_wen",  32'(ex_wen), 32'd1);
      check("addi_busy1", 32'(dut.busy_q[1]), 32'd1);

      // ADD x2,x1,x1 stalls, then resolves via writeback of x1
      drive(1'b1, 32'h00108133, 16'h0004, 1'b0, 1'b0, 5'd0, 32'h0);
      check("raw_bubble", 32'(ex_v), 32'd0);
      drive(1'b1, 32'h00108133, 16'h0004, 1'b0, 1'b1, 5'd1, 32'd5);
      check("raw_rs1", ex_rs1_val, 32'd5);
      check("raw_rs2", ex_rs2_val, 32'd5);

      // Writeback to x0 is ignored, including on the bypass path
      drive(1'b1, 32'h00000313, 16'h0008, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
      check("x0_rs1",   ex_rs1_val, 32'h0);
      check("x0_mem",   dut.u_regfile.mem_q[0], 32'h0);
      check("x0_busy",  32'(dut.busy_q[0]), 32'h0);

      // Flush: ADDI x3 in EX, LW x4 in DE
      drive(1'b1, 32'h00100193, 16'h000C, 1'b0, 1'b0, 5'd0, 32'h0);
      drive(1'b1, 32'h00002203, 16'h0010, 1'b1, 1'b0, 5'd0, 32'h0);
      check("flush_v",  32'(ex_v), 32'd0);
      check("flush_b3", 32'(dut.busy_q[3]), 32'd0);
      check("flush_b4", 32'(dut.busy_q[4]), 32'd0);

      // Immediate forms
      drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b1, 5'd2, 32'h0000_0100);
      drive(1'b1, 32'hFE112E23, 16'h0020, 1'b0, 1'b0, 5'd0, 32'h0);
      check("imm_s", ex_imm, 32'hFFFFFFFC);
      drive(1'b1, 32'h0080006F, 16'h0024, 1'b0, 1'b0, 5'd0, 32'h0);
      check("imm_j", ex_imm, 32'd8);
      drive(1'b1, 32'h123452B7, 16'h0028, 1'b0, 1'b0, 5'd0, 32'h0);
      check("imm_u", ex_imm, 32'h12345000);

      // Random traffic; fetch holds its instruction while the model predicts a stall
      for (int n = 0; n < 3000; n++) begin
         if (!stall_prev) begin
            rand_instr(ir);
            de_ir = ir;
            de_v  = ($urandom_range(0, 7) != 0);
            de_pc = 16'($urandom);
         end
         me_brt  = ($urandom_range(0, 15) == 0);
         wb_wen  = $urandom_range(0, 1) == 1;
         wb_rd   = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         cycle();
      end

      // Reset in the middle of traffic overrides flush and writeback
      de_v = 1'b1; me_brt = 1'b1; wb_wen = 1'b1; wb_rd = 5'd5; wb_data = $urandom;
      do_reset();
      for (int n = 0; n < 200; n++) begin
         if (!stall_prev) begin
            rand_instr(ir);
            de_ir = ir;
            de_v  = 1'b1;
            de_pc = 16'($urandom);
         end
         me_brt  = 1'b0;
         wb_wen  = $urandom_range(0, 3) == 0;
         wb_rd   = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
